// File: rtl/mips_pkg.sv
// Package shared by the fetch front end.
// Holds the fetch FSM state encoding, the instruction field positions used to
// slice opcode/funct, datapath widths, the reset value of the instruction
// output, and a helper that forces an address onto a word boundary.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {pc, instr} pairs.
// Ports: clk/reset (synchronous, active-high); push with push_pc/push_instr;
// pop; flush; head_pc/head_instr (registered head, holds last value when
// empty); count, full, empty.
// flush wins over push; a pop in the same cycle as flush still retires the
// current head. The head registers are loaded with the entry that will be at
// the head after this cycle, so they never expose a stale slot.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_pc,
  input  logic [INSTR_W-1:0]       push_instr,
  input  logic                     pop,
  input  logic                     flush,
  output logic [ADDR_W-1:0]        head_pc,
  output logic [INSTR_W-1:0]       head_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  head_pc_q, head_pc_d;
  logic [INSTR_W-1:0] head_instr_q, head_instr_d;
  logic [PTR_W-1:0]   next_rd;
  logic               do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~flush & ~full;

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    next_rd      = rd_ptr_q + PTR_W'(do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = next_rd;
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (count_d != '0) begin
        // Buffer drains to nothing after the pop: the new head is the word
        // being pushed; otherwise it is already stored at next_rd.
        if ((count_q - CNT_W'(do_pop)) == '0) begin
          head_pc_d    = push_pc;
          head_instr_d = push_instr;
        end else begin
          head_pc_d    = pc_mem_q[next_rd];
          head_instr_d = instr_mem_q[next_rd];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_pc_q    <= '0;
      head_instr_q <= NOP_INSTR;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem_q[wr_ptr_q]    <= push_pc;
      instr_mem_q[wr_ptr_q] <= push_instr;
    end
  end

  assign head_pc    = head_pc_q;
  assign head_instr = head_instr_q;
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: keeps the fetch PC, issues at most one instruction
// memory request at a time, buffers returned words in fetch_fifo and presents
// the head to decode. A redirect from execute flushes the buffer and restarts
// fetch at the (word-aligned) target.
// Ports: clk, reset (synchronous, active-high); imem_req/imem_addr out,
// imem_ack/imem_rdata in; redirect/redirect_pc in; dec_valid out, dec_ready in;
// instr, opcode, funct, pc, pcplus4 out; dbg_state out (current fetch state).
//
// Handshakes: decode takes the head on a cycle where dec_valid && dec_ready;
// dec_valid stays high and the head stays stable until taken. Memory returns
// data on a cycle where imem_req && imem_ack; imem_req and imem_addr stay
// stable until then, and imem_ack is meaningless while imem_req is low.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic [5:0]         funct,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pcplus4,
  output fetch_state_t       dbg_state
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;     // restart address held while draining

  logic              ack_v, push, pop, space;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count, cnt_after;
  logic [ADDR_W-1:0] redir_pc;
  logic              redirect_pc_unused;

  assign redirect_pc_unused = ^redirect_pc[1:0];
  assign redir_pc = word_align(redirect_pc);
  assign ack_v    = imem_ack & req_q;
  assign pop      = dec_valid & dec_ready;
  assign push     = ack_v & (state_q == REQ) & ~redirect & ~fifo_full;

  // Occupancy after this edge; a new request is allowed only if it leaves room.
  assign cnt_after = redirect ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign space     = (cnt_after < CNT_W'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    tgt_d   = tgt_q;
    case (state_q)
      IDLE: begin
        if (redirect) addr_d = redir_pc;
        if (space) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        if (redirect) begin
          if (ack_v) begin
            addr_d = redir_pc;       // acked word dropped, restart right away
          end else begin
            tgt_d   = redir_pc;      // request still in flight: wait it out
            state_d = DRAIN;
          end
        end else if (ack_v) begin
          addr_d = addr_q + 32'd4;
          if (!space) begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (ack_v) begin
          addr_d  = redirect ? redir_pc : tgt_q;
          state_d = REQ;
        end else if (redirect) begin
          tgt_d = redir_pc;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      tgt_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_pc    (addr_q),
    .push_instr (imem_rdata),
    .pop        (pop),
    .flush      (redirect),
    .head_pc    (pc),
    .head_instr (instr),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign dec_valid = ~fifo_empty;
  assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];
  assign funct     = instr[FUNCT_MSB:FUNCT_LSB];
  assign pcplus4   = pc + 32'd4;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Instance u_dut uses the default
// 2-entry buffer; u_dut4 (4 entries, RESET_PC 0x10) is used for the scenario
// that needs two buffered words plus a request in flight.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  logic clk, reset;

  logic        imem_req, imem_ack, redirect, dec_valid, dec_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, pc, pcplus4;
  logic [5:0]  opcode, funct;
  fetch_state_t dbg_state;

  logic        imem_req_b, imem_ack_b, redirect_b, dec_valid_b, dec_ready_b;
  logic [31:0] imem_addr_b, imem_rdata_b, redirect_pc_b, instr_b, pc_b, pcplus4_b;
  logic [5:0]  opcode_b, funct_b;
  fetch_state_t dbg_state_b;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .instr(instr), .opcode(opcode), .funct(funct),
    .pc(pc), .pcplus4(pcplus4), .dbg_state(dbg_state)
  );

  instr_fetch_unit #(.RESET_PC(32'h0000_0010), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b),
    .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b),
    .redirect(redirect_b), .redirect_pc(redirect_pc_b),
    .dec_valid(dec_valid_b), .dec_ready(dec_ready_b),
    .instr(instr_b), .opcode(opcode_b), .funct(funct_b),
    .pc(pc_b), .pcplus4(pcplus4_b), .dbg_state(dbg_state_b)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Memory contents: lw-style word carrying the low address bits
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h8C22_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait memory: answer whatever is requested this cycle
  task automatic mem_zw();
    imem_ack   = imem_req;
    imem_rdata = mem_word(imem_addr);
  endtask

  task automatic mem_zw_b();
    imem_ack_b   = imem_req_b;
    imem_rdata_b = mem_word(imem_addr_b);
  endtask

  // Fixed-latency memory: ack on the lat-th cycle of the current request
  task automatic mem_lat(input int lat);
    for (int i = 0; i < lat - 1; i++) begin
      imem_ack = 1'b0;
      tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = mem_word(imem_addr);
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_ack = 1'b0; redirect = 1'b0; dec_ready = 1'b0;
    imem_ack_b = 1'b0; redirect_b = 1'b0; dec_ready_b = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    imem_rdata = '0; redirect_pc = '0;
    imem_rdata_b = '0; redirect_pc_b = '0;
    do_reset();

    // Reset values
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", dec_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", dbg_state, IDLE);

    // Zero-wait streaming with decode always ready
    reset = 1'b0; dec_ready = 1'b1; mem_zw();
    tick();
    chk("s_req1", imem_req, 1'b1);
    chk("s_addr1", imem_addr, 32'h0);
    mem_zw(); tick();
    chk("s_addr2", imem_addr, 32'h4);
    chk("s_valid2", dec_valid, 1'b1);
    chk("s_pc2", pc, 32'h0);
    chk("s_pc4_2", pcplus4, 32'h4);
    mem_zw(); tick();
    chk("s_addr3", imem_addr, 32'h8);
    chk("s_valid3", dec_valid, 1'b1);
    chk("s_pc3", pc, 32'h4);
    chk("s_instr3", instr, 32'h8C22_0004);
    chk("s_opcode3", opcode, 6'h23);
    chk("s_funct3", funct, 6'h04);
    mem_zw(); tick();
    chk("s_addr4", imem_addr, 32'hC);
    chk("s_valid4", dec_valid, 1'b1);
    chk("s_pc4", pc, 32'h8);

    // Back-pressure: buffer fills after two acks, fetch stops
    do_reset();
    reset = 1'b0; mem_zw();
    tick();
    mem_zw(); tick();
    chk("bp_req2", imem_req, 1'b1);
    chk("bp_addr2", imem_addr, 32'h4);
    chk("bp_pc2", pc, 32'h0);
    mem_zw(); tick();
    chk("bp_req3", imem_req, 1'b0);
    chk("bp_state3", dbg_state, IDLE);
    mem_zw(); tick();
    chk("bp_req4", imem_req, 1'b0);
    chk("bp_head4", pc, 32'h0);
    dec_ready = 1'b1; mem_zw(); tick();
    chk("bp_pc5", pc, 32'h4);
    chk("bp_valid5", dec_valid, 1'b1);
    chk("bp_req5", imem_req, 1'b1);
    chk("bp_addr5", imem_addr, 32'h8);

    // Redirect while a 3-cycle request is in flight -> drain
    do_reset();
    reset = 1'b0; dec_ready = 1'b1;
    tick();
    mem_lat(3);
    mem_lat(3);
    chk("dr_addr_pre", imem_addr, 32'h8);
    chk("dr_pc_pre", pc, 32'h4);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("dr_state", dbg_state, DRAIN);
    chk("dr_req", imem_req, 1'b1);
    chk("dr_addr_hold", imem_addr, 32'h8);
    chk("dr_valid", dec_valid, 1'b0);
    tick();
    chk("dr_addr_hold2", imem_addr, 32'h8);
    imem_ack = 1'b1; imem_rdata = mem_word(32'h8);
    tick();
    imem_ack = 1'b0;
    chk("dr_new_addr", imem_addr, 32'h100);
    chk("dr_drop", dec_valid, 1'b0);
    mem_lat(3);
    chk("dr_valid_t", dec_valid, 1'b1);
    chk("dr_pc_t", pc, 32'h100);
    chk("dr_pcplus4_t", pcplus4, 32'h104);

    // Redirect coinciding with a pop and an ack (4-entry instance)
    do_reset();
    reset = 1'b0; mem_zw_b();
    tick();
    mem_zw_b(); tick();
    mem_zw_b(); tick();
    chk("rp_valid_pre", dec_valid_b, 1'b1);
    chk("rp_pc_pre", pc_b, 32'h10);
    chk("rp_addr_pre", imem_addr_b, 32'h18);
    mem_zw_b(); dec_ready_b = 1'b1; redirect_b = 1'b1; redirect_pc_b = 32'h0000_0040;
    tick();
    redirect_b = 1'b0;
    chk("rp_flushed", dec_valid_b, 1'b0);
    chk("rp_hold_pc", pc_b, 32'h10);
    chk("rp_addr_t", imem_addr_b, 32'h40);
    chk("rp_req_t", imem_req_b, 1'b1);
    mem_zw_b(); tick();
    chk("rp_valid_t", dec_valid_b, 1'b1);
    chk("rp_pc_t", pc_b, 32'h40);
    chk("rp_instr_t", instr_b, 32'h8C22_0040);

    // Redirect to the top word: pc + 4 and fetch address wrap to zero
    do_reset();
    reset = 1'b0; dec_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    chk("wr_addr1", imem_addr, 32'hFFFF_FFFC);
    mem_zw(); tick();
    chk("wr_pc", pc, 32'hFFFF_FFFC);
    chk("wr_pcplus4", pcplus4, 32'h0);
    chk("wr_addr2", imem_addr, 32'h0);
    chk("wr_valid", dec_valid, 1'b1);

    // Reset with a request outstanding, then a late ack
    imem_ack = 1'b0; reset = 1'b1;
    tick();
    chk("lr_req", imem_req, 1'b0);
    chk("lr_valid", dec_valid, 1'b0);
    chk("lr_state", dbg_state, IDLE);
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("lr_nopush", dec_valid, 1'b0);
    chk("lr_req1", imem_req, 1'b1);
    chk("lr_addr1", imem_addr, 32'h0);
    tick();
    chk("lr_nopush2", dec_valid, 1'b0);
    imem_ack = 1'b1; imem_rdata = mem_word(32'h0);
    tick();
    imem_ack = 1'b0;
    chk("lr_valid_ok", dec_valid, 1'b1);
    chk("lr_pc_ok", pc, 32'h0);
    chk("lr_instr_ok", instr, 32'h8C22_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
